// File: rtl/sseg_scan.sv
// Time-multiplexed hex seven-segment scanner: frame-synchronous word load, dead-time
// digit scanning, leading-zero blanking, per-digit decimal points and whole-display blink.
module sseg_scan #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 8,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 4,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit DIG_ACT_LOW  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [6:0]            segs,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [6:0]        SEG_OFF  = {7{SEG_ACT_LOW}};
  localparam logic              DP_OFF   = SEG_ACT_LOW;
  localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_ACT_LOW}};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return SEG_ACT_LOW ? ~s : s;
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_full_q, pend_full_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [6:0]          segs_q, segs_d;
  logic                seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]   sel_q, sel_d;

  logic                tick, frame_end, accept, commit, blanked, zero_run;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_lz;
  logic [DIGITS-1:0]   lz_blank, sel_hot;

  assign data_ready = ~pend_full_q;

  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    frame_end = tick && (idx_q == IDX_LAST);
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // Accept and commit are exclusive: ready is low whenever a word is waiting.
    accept      = data_valid && !pend_full_q;
    commit      = frame_end && pend_full_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    if (commit) begin
      disp_d      = pend_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_d      = data;
      pend_dp_d   = dp;
      pend_full_d = 1'b1;
    end

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    // Walk from the most significant digit down while nibbles stay zero.
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run && (disp_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run && (i != 0);
    end

    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    sel_hot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib    = disp_q[4*i +: 4];
        cur_dp     = disp_dp_q[i];
        cur_lz     = lz_blank[i];
        sel_hot[i] = 1'b1;
      end
    end

    blanked  = (blink_en && phase_q) || (blank_lz && cur_lz);
    segs_d   = blanked ? SEG_OFF : seg_pol(hex_to_seg(cur_nib));
    seg_dp_d = (blanked || !cur_dp) ? DP_OFF : ~DP_OFF;
    sel_d    = (cnt_q >= CNT_DEAD) ? (DIG_ACT_LOW ? ~sel_hot : sel_hot) : DIG_OFF;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      segs_q      <= SEG_OFF;
      seg_dp_q    <= DP_OFF;
      sel_q       <= DIG_OFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      segs_q      <= segs_d;
      seg_dp_q    <= seg_dp_d;
      sel_q       <= sel_d;
    end
  end

  assign segs      = segs_q;
  assign seg_dp    = seg_dp_q;
  assign digit_sel = sel_q;

endmodule
